// File: rtl/plc_tx_framer_pkg.sv
// Shared types and line levels for the PLC transmit framer.
package plc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    START,
    DATA,
    STOP
  } plcState_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  // Preamble alternates 1,0,1,0,... starting from symbol index 0.
  function automatic logic preambleLevel(input logic indexLsb);
    return ~indexLsb;
  endfunction

endpackage

// File: rtl/plc_tx_framer_symbol_timer.sv
// Symbol period counter: strobes the first cycle and flags the last cycle of each symbol.
module plc_symbol_timer #(
  parameter int CYCLES_PER_SYMBOL = 100,
  parameter int CNT_WIDTH         = 16
) (
  input  logic BusClk,
  input  logic BusReset_n,
  input  logic Clear,
  output logic SymStrobe,
  output logic SymEnd
);

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(CYCLES_PER_SYMBOL - 1);

  logic [CNT_WIDTH-1:0] symCnt;

  always_ff @(posedge BusClk or negedge BusReset_n) begin
    if (!BusReset_n) begin
      symCnt <= '0;
    end else if (Clear || symCnt == LastCnt) begin
      symCnt <= '0;
    end else begin
      symCnt <= symCnt + CNT_WIDTH'(1);
    end
  end

  assign SymStrobe = !Clear && (symCnt == '0);
  assign SymEnd    = !Clear && (symCnt == LastCnt);

endmodule

// File: rtl/plc_tx_framer.sv
// Byte-to-symbol framer: preamble per burst, start/data/stop per byte, one bit per symbol.
module plc_tx_framer
  import plc_pkg::*;
#(
  parameter int CYCLES_PER_SYMBOL = 100,
  parameter int PREAMBLE_BITS     = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic       BusClk,
  input  logic       BusReset_n,
  input  logic       TxEnable,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       SymBit,
  output logic       SymStrobe,
  output logic       SymActive,
  output logic       TxBusy,
  output logic       TxDone
);

  localparam int MaxBits     = (PREAMBLE_BITS > DATA_BITS) ? PREAMBLE_BITS : DATA_BITS;
  localparam int BitCntWidth = $clog2(MaxBits) + 1;
  localparam logic [BitCntWidth-1:0] LastPreamble = BitCntWidth'(PREAMBLE_BITS - 1);
  localparam logic [BitCntWidth-1:0] LastData     = BitCntWidth'(DATA_BITS - 1);

  plcState_e              state;
  logic [7:0]             holdData;
  logic                   holdValid;
  logic [7:0]             shiftReg;
  logic [BitCntWidth-1:0] bitCnt;
  logic [BitCntWidth-1:0] bitCntInc;
  logic                   symBit;
  logic                   symActive;
  logic                   txDone;
  logic                   symEnd;
  logic                   accept;

  assign TxReady   = TxEnable && !holdValid;
  assign accept    = TxValid && TxReady;
  assign bitCntInc = bitCnt + BitCntWidth'(1);

  plc_symbol_timer #(
    .CYCLES_PER_SYMBOL(CYCLES_PER_SYMBOL),
    .CNT_WIDTH        (CNT_WIDTH)
  ) symbolTimer (
    .BusClk    (BusClk),
    .BusReset_n(BusReset_n),
    .Clear     (state == IDLE),
    .SymStrobe (SymStrobe),
    .SymEnd    (symEnd)
  );

  // SymBit/SymActive are registered with the value belonging to the state being entered.
  always_ff @(posedge BusClk or negedge BusReset_n) begin
    if (!BusReset_n) begin
      state     <= IDLE;
      holdData  <= '0;
      holdValid <= 1'b0;
      shiftReg  <= '0;
      bitCnt    <= '0;
      symBit    <= IDLE_LEVEL;
      symActive <= 1'b0;
      txDone    <= 1'b0;
    end else begin
      txDone <= 1'b0;
      if (!TxEnable) begin
        state     <= IDLE;
        holdValid <= 1'b0;
        bitCnt    <= '0;
        symBit    <= IDLE_LEVEL;
        symActive <= 1'b0;
      end else begin
        if (accept) begin
          holdData  <= TxData;
          holdValid <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (holdValid) begin
              state     <= PREAMBLE;
              shiftReg  <= holdData;
              holdValid <= 1'b0;
              bitCnt    <= '0;
              symBit    <= preambleLevel(1'b0);
              symActive <= 1'b1;
            end
          end
          PREAMBLE: begin
            if (symEnd) begin
              if (bitCnt == LastPreamble) begin
                state  <= START;
                bitCnt <= '0;
                symBit <= START_BIT;
              end else begin
                bitCnt <= bitCntInc;
                symBit <= preambleLevel(bitCntInc[0]);
              end
            end
          end
          START: begin
            if (symEnd) begin
              state  <= DATA;
              bitCnt <= '0;
              symBit <= shiftReg[0];
            end
          end
          DATA: begin
            if (symEnd) begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              if (bitCnt == LastData) begin
                state  <= STOP;
                bitCnt <= '0;
                symBit <= STOP_BIT;
              end else begin
                bitCnt <= bitCntInc;
                symBit <= shiftReg[1];
              end
            end
          end
          STOP: begin
            if (symEnd) begin
              if (holdValid) begin
                // Chained byte: skip the preamble, go straight to its start bit.
                state     <= START;
                shiftReg  <= holdData;
                holdValid <= 1'b0;
                symBit    <= START_BIT;
              end else begin
                state     <= IDLE;
                symBit    <= IDLE_LEVEL;
                symActive <= 1'b0;
                txDone    <= 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            symBit    <= IDLE_LEVEL;
            symActive <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SymBit    = symBit;
  assign SymActive = symActive;
  assign TxDone    = txDone;
  assign TxBusy    = (state != IDLE) || holdValid;

endmodule

// File: tb/tb_plc_tx_framer.sv
// Bench for plc_tx_framer: captured symbol bursts are compared with frames built from the written bytes.
module tb_plc_tx_framer;

  localparam int C = 4;
  localparam int P = 4;

  logic       BusClk = 1'b0;
  logic       BusReset_n;
  logic       TxEnable;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady;
  logic       SymBit;
  logic       SymStrobe;
  logic       SymActive;
  logic       TxBusy;
  logic       TxDone;

  plc_tx_framer #(
    .CYCLES_PER_SYMBOL(C),
    .PREAMBLE_BITS    (P),
    .CNT_WIDTH        (16)
  ) dut (
    .BusClk    (BusClk),
    .BusReset_n(BusReset_n),
    .TxEnable  (TxEnable),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .SymBit    (SymBit),
    .SymStrobe (SymStrobe),
    .SymActive (SymActive),
    .TxBusy    (TxBusy),
    .TxDone    (TxDone)
  );

  always #5 BusClk = ~BusClk;

  int checks   = 0;
  int failures = 0;
  int cycleCnt = 0;

  always @(posedge BusClk) cycleCnt <= cycleCnt + 1;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Burst monitor: a burst is a run of cycles with SymActive high.
  logic curBits[$];
  logic lastBits[$];
  int   curLen, lastLen, holdErrs, lastHoldErrs;
  int   burstCount = 0;
  int   doneCount  = 0;
  bit   inBurst    = 0;
  logic lastSym    = 1'b1;

  initial begin
    forever begin
      @(negedge BusClk);
      if (SymActive === 1'b1) begin
        if (!inBurst) begin
          curBits.delete();
          curLen   = 0;
          holdErrs = 0;
          inBurst  = 1;
        end
        curLen++;
        if (SymStrobe === 1'b1) begin
          curBits.push_back(SymBit);
          lastSym = SymBit;
        end else if (SymBit !== lastSym) begin
          holdErrs++;
        end
      end else if (inBurst) begin
        inBurst      = 0;
        lastBits     = curBits;
        lastLen      = curLen;
        lastHoldErrs = holdErrs;
        burstCount++;
      end
      if (TxDone === 1'b1) doneCount++;
    end
  end

  // Reference frame: alternating preamble, then {start, 8 data bits LSB first, stop} per byte.
  task automatic buildFrame(input logic [7:0] bytes[$], output logic [63:0] bits, output int nBits);
    bits  = '0;
    nBits = 0;
    for (int i = 0; i < P; i++) begin
      bits[nBits] = (i % 2 == 0);
      nBits++;
    end
    foreach (bytes[k]) begin
      bits[nBits] = 1'b0;
      nBits++;
      for (int j = 0; j < 8; j++) begin
        bits[nBits] = bytes[k][j];
        nBits++;
      end
      bits[nBits] = 1'b1;
      nBits++;
    end
  endtask

  function automatic logic [63:0] packLast();
    logic [63:0] v = '0;
    foreach (lastBits[i]) if (i < 64) v[i] = lastBits[i];
    return v;
  endfunction

  int snapBursts, snapDone;

  task automatic snapshot();
    snapBursts = burstCount;
    snapDone   = doneCount;
  endtask

  // Offers one byte and returns #1 after the edge on which it transferred.
  task automatic sendByte(input logic [7:0] b);
    bit accepted = 0;
    TxData  = b;
    TxValid = 1'b1;
    for (int i = 0; i < 2000 && !accepted; i++) begin
      @(negedge BusClk);
      if (TxReady === 1'b1) begin
        accepted = 1;
        @(posedge BusClk);
        #1;
      end
    end
    TxValid = 1'b0;
    if (!accepted) checkEq("accept_timeout", 64'(accepted), 64'd1);
  endtask

  task automatic waitBurst();
    for (int i = 0; i < 3000 && burstCount == snapBursts; i++) @(posedge BusClk);
    repeat (2) @(posedge BusClk);
    #1;
    checkEq("burst_seen", 64'(burstCount - snapBursts), 64'd1);
  endtask

  task automatic checkBurst(input string tag, input logic [7:0] bytes[$]);
    logic [63:0] expBits;
    int          expN;
    buildFrame(bytes, expBits, expN);
    waitBurst();
    checkEq({tag, "_len"}, 64'(lastLen), 64'((P + 10 * bytes.size()) * C));
    checkEq({tag, "_nsym"}, 64'(lastBits.size()), 64'(expN));
    checkEq({tag, "_bits"}, packLast(), expBits);
    checkEq({tag, "_hold"}, 64'(lastHoldErrs), 64'd0);
    checkEq({tag, "_done"}, 64'(doneCount - snapDone), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [63:0] expBits;
    int          expN;
    int          tE1;
    int          nB;
    int          badCycles;

    BusReset_n = 1'b0;
    TxEnable   = 1'b0;
    TxValid    = 1'b0;
    TxData     = 8'h00;
    repeat (3) @(negedge BusClk);
    checkEq("rst_ready", 64'(TxReady), 64'd0);
    checkEq("rst_symbit", 64'(SymBit), 64'd1);
    checkEq("rst_strobe", 64'(SymStrobe), 64'd0);
    checkEq("rst_active", 64'(SymActive), 64'd0);
    checkEq("rst_busy", 64'(TxBusy), 64'd0);
    checkEq("rst_done", 64'(TxDone), 64'd0);
    BusReset_n = 1'b1;
    @(posedge BusClk);
    #1;
    TxEnable = 1'b1;
    #1;
    checkEq("ready_enabled", 64'(TxReady), 64'd1);

    // Single byte with latency checks.
    snapshot();
    sendByte(8'h65);
    checkEq("single_ready_e0", 64'(TxReady), 64'd0);
    @(posedge BusClk);
    #1;
    checkEq("single_ready_e1", 64'(TxReady), 64'd1);
    checkEq("single_strobe_e1", 64'(SymStrobe), 64'd1);
    checkEq("single_active_e1", 64'(SymActive), 64'd1);
    q = '{8'h65};
    checkBurst("single", q);

    // Back-to-back, second byte offered while the first is still pending.
    snapshot();
    sendByte(8'h65);
    sendByte(8'hA3);
    q = '{8'h65, 8'hA3};
    checkBurst("b2b", q);

    // Backpressure: three bytes with TxValid held continuously.
    snapshot();
    sendByte(8'h11);
    sendByte(8'hE7);
    sendByte(8'h3C);
    q = '{8'h11, 8'hE7, 8'h3C};
    checkBurst("bp", q);

    // Randomized bursts with short random gaps between writes.
    for (int t = 0; t < 6; t++) begin
      q.delete();
      nB = $urandom_range(1, 4);
      snapshot();
      for (int k = 0; k < nB; k++) begin
        q.push_back(8'($urandom));
        repeat ($urandom_range(0, 5)) @(posedge BusClk);
        #1;
        sendByte(q[k]);
      end
      checkBurst($sformatf("rand%0d", t), q);
      repeat ($urandom_range(0, 7)) @(posedge BusClk);
      #1;
    end

    // Abort during DATA bit 3 with a second byte waiting in the holding register.
    snapshot();
    sendByte(8'h5A);
    @(posedge BusClk);
    #1;
    tE1 = cycleCnt;
    sendByte(8'hC3);
    while (cycleCnt < tE1 + 33) begin
      @(posedge BusClk);
      #1;
    end
    checkEq("abort_busy_before", 64'(TxBusy), 64'd1);
    TxEnable = 1'b0;
    @(posedge BusClk);
    #1;
    checkEq("abort_active", 64'(SymActive), 64'd0);
    checkEq("abort_busy", 64'(TxBusy), 64'd0);
    checkEq("abort_symbit", 64'(SymBit), 64'd1);
    repeat (4) @(posedge BusClk);
    #1;
    checkEq("abort_done", 64'(doneCount - snapDone), 64'd0);
    checkEq("abort_burst", 64'(burstCount - snapBursts), 64'd1);
    checkEq("abort_len", 64'(lastLen), 64'd34);
    checkEq("abort_nsym", 64'(lastBits.size()), 64'd9);
    q = '{8'h5A};
    buildFrame(q, expBits, expN);
    checkEq("abort_bits", packLast(), expBits & 64'h1FF);
    TxEnable = 1'b1;
    snapshot();
    q = '{8'($urandom)};
    sendByte(q[0]);
    checkBurst("after_abort", q);

    // Disabled: offered data is never taken and nothing is sent.
    TxEnable  = 1'b0;
    TxValid   = 1'b1;
    TxData    = 8'hFF;
    badCycles = 0;
    snapshot();
    for (int i = 0; i < 20; i++) begin
      @(negedge BusClk);
      if (TxReady !== 1'b0 || SymActive !== 1'b0 || SymStrobe !== 1'b0) badCycles++;
    end
    checkEq("disabled_quiet", 64'(badCycles), 64'd0);
    checkEq("disabled_bursts", 64'(burstCount - snapBursts), 64'd0);
    TxValid  = 1'b0;
    @(posedge BusClk);
    #1;
    TxEnable = 1'b1;

    // Asynchronous reset in the middle of the preamble.
    sendByte(8'h96);
    repeat (5) @(posedge BusClk);
    #3;
    BusReset_n = 1'b0;
    #1;
    checkEq("arst_active", 64'(SymActive), 64'd0);
    checkEq("arst_symbit", 64'(SymBit), 64'd1);
    checkEq("arst_busy", 64'(TxBusy), 64'd0);
    checkEq("arst_strobe", 64'(SymStrobe), 64'd0);
    repeat (2) @(posedge BusClk);
    #3;
    BusReset_n = 1'b1;
    repeat (2) @(posedge BusClk);
    #1;
    snapshot();
    q = '{8'h4D};
    sendByte(q[0]);
    checkBurst("after_rst", q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plc_tx_framer.md
Name: plc_tx_framer

Overview:
- Transmit framer directly downstream of the PLC control/register block.
- Consumes bytes written to the PLC TX data register through a valid/ready handshake, wraps each burst in a preamble and each byte in start/stop bits, and emits one bit per symbol period to the BPSK modulator.
- Owns symbol timing; the modulator only follows SymBit/SymStrobe/SymActive.

Parameters:
- CYCLES_PER_SYMBOL, 100, BusClk cycles per symbol (2 MSym/s at 200 MHz); legal range >= 2.
- PREAMBLE_BITS, 8, alternating 1,0,... symbols sent before the first byte of a burst; legal range >= 1.
- CNT_WIDTH, 16, symbol-counter width; must hold CYCLES_PER_SYMBOL-1.

Ports:
- BusClk  in  1  clock.
- BusReset_n  in  1  reset.
- TxEnable  in  1  transmitter enable from the PLC control register.
- TxData  in  8  byte to transmit.
- TxValid  in  1  TxData valid.
- TxReady  out  1  holding register free; a byte transfers on a BusClk edge where TxValid && TxReady.
- SymBit  out  1  current symbol value to the modulator.
- SymStrobe  out  1  one-cycle pulse on the first cycle of every symbol.
- SymActive  out  1  carrier on; high for every cycle of a burst.
- TxBusy  out  1  state != IDLE or holding register full.
- TxDone  out  1  one-cycle pulse when a burst ends normally.

Behaviour:
- Reset is BusReset_n, asynchronous, active-low; clock is BusClk.
- Reset values: state IDLE, holding register empty, TxReady=0 (it follows TxEnable after reset), SymBit=1, SymStrobe=0, SymActive=0, TxBusy=0, TxDone=0, all counters 0.
- TxReady = TxEnable && !HoldValid. This output is combinational from registers plus TxEnable.
- There is one holding register (HoldData, HoldValid) and one 8-bit shift register. The holding register loads on an accept edge.
- States:
  - IDLE: SymActive=0, SymBit=1. If TxEnable && HoldValid, go to PREAMBLE, move HoldData into the shift register, clear HoldValid, set SymCnt=0 and BitCnt=0.
  - PREAMBLE: SymBit = BitCnt[0] ? 0 : 1. After PREAMBLE_BITS symbols, go to START.
  - START: SymBit=0 for one symbol, then go to DATA.
  - DATA: SymBit = shift[0] (LSB first); shift right at each symbol end. After 8 symbols, go to STOP.
  - STOP: SymBit=1 for one symbol. At its end:
    - if HoldValid, reload the shift register, clear HoldValid and go to START (no preamble);
    - else go to IDLE and pulse TxDone in the first IDLE cycle.
- Symbol timing:
  - SymCnt counts 0..CYCLES_PER_SYMBOL-1 in every non-IDLE state.
  - The symbol ends on the cycle where SymCnt==CYCLES_PER_SYMBOL-1; the state/bit advance happens on that edge and SymCnt wraps to 0.
  - SymStrobe = (state != IDLE) && SymCnt==0.
- Latency: byte accepted at edge E0 (from IDLE) -> state PREAMBLE after E1 -> first SymStrobe in the cycle after E1. TxReady is high again after E1.
- Burst length: (PREAMBLE_BITS + 10*N) * CYCLES_PER_SYMBOL cycles for N back-to-back bytes.
- Simultaneous events:
  - If an accept coincides with the STOP-end edge while HoldValid=0, the byte is not seen in time; the framer goes to IDLE, pulses TxDone, then starts a new burst with preamble.
  - If HoldValid=1 on that edge, TxReady=0, so no accept can coincide.
- TxEnable deassert, in any state: abort on the next edge.
  - State goes to IDLE and the holding register is flushed.
  - SymActive drops in the following cycle.
  - No TxDone; no partial-symbol completion.
- Reset mid-burst: all outputs return immediately (asynchronously) to their reset values.

Decomposition:
- Package plc_pkg holds:
  - the state enum (IDLE, PREAMBLE, START, DATA, STOP);
  - START_BIT=0 and STOP_BIT=1;
  - IDLE_LEVEL=1;
  - DATA_BITS=8.
- Sub-module plc_symbol_timer holds SymCnt and produces SymStrobe and the SymEnd pulse. It is parameterised by CYCLES_PER_SYMBOL and CNT_WIDTH, with a clear input driven when state is IDLE.

Test Plan:
All scenarios use CYCLES_PER_SYMBOL=4, PREAMBLE_BITS=4.
- Single byte: TxEnable=1, write 0x65 -> SymBit sequence 1,0,1,0 | 0 | 1,0,1,0,0,1,1,0 | 1. Each bit is held 4 cycles with a SymStrobe per bit; SymActive high 56 cycles; one TxDone pulse; TxReady high again one cycle after the accept.
- Back-to-back: write 0x65, then 0xA3 while busy -> TxReady low until the first frame leaves IDLE. Second frame has no preamble: stop of byte 1 is followed directly by start of byte 2, with data bits 1,1,0,0,0,1,0,1. 96-cycle burst, exactly one TxDone.
- Backpressure: hold TxValid=1 with three bytes queued -> TxReady deasserts while the holding register is full; no byte is lost or duplicated; transmitted order matches write order.
- Abort: deassert TxEnable during DATA bit 3 -> IDLE next edge, SymActive low the following cycle, holding register flushed, no TxDone. Re-enable plus a new byte restarts with the full preamble.
- Disabled: TxEnable=0, TxValid=1 -> TxReady=0, no symbols, SymActive stays 0.
- Async reset mid-PREAMBLE: BusReset_n low between clock edges -> SymActive=0, SymBit=1, TxBusy=0 immediately. After release, the next accepted byte is framed normally.
